bp_meta_ftq: RTL and testbench
==============================

// Module: bp_meta_ftq
// PURPOSE
//  Fetch-target metadata queue sitting between the tournament predictor and execute-side update.
//  Per fetch block it captures the predictor's gindex/lindex and per-slot gbp/lbp predictions at lookup time.
//  On in-order branch resolution it replays that metadata, registered, to the predictor update ports.
//  Flushed on frontend redirect.
// PARAMETERS
//  CVA6Cfg      cva6_cfg_empty  supplies VLEN, INSTR_PER_FETCH (IPF), GlobalPredictorIndexBits (GW), LocalPredictorIndexBits (LW)
//  bht_prediction_t  logic      per-slot prediction struct {valid, taken}; width PW
//  DEPTH        8               entries; power of two, >=2
// PORTS
//  clk_i               in   1          clock
//  rst_ni              in   1          synchronous reset, active low
//  flush_i             in   1          redirect/flush: drop all entries
//  push_valid_i        in   1          fetch block looked up this cycle
//  push_ready_o        out  1          queue can accept (count<DEPTH)
//  push_vpc_i          in   VLEN       fetch block vpc
//  push_gindex_i       in   GW         gindex from predictor
//  push_lindex_i       in   LW         lindex from predictor
//  push_gbp_pred_i     in   IPF*PW     gbp per-slot predictions
//  push_lbp_pred_i     in   IPF*PW     lbp per-slot predictions
//  resolve_valid_i     in   1          branch resolved; retire head entry
//  resolve_pc_i        in   VLEN       pc of resolved branch
//  update_valid_o      out  1          metadata valid for predictor update
//  update_gindex_o     out  GW         head gindex, registered
//  update_lindex_o     out  LW         head lindex, registered
//  update_gbp_pred_o   out  IPF*PW     head gbp predictions, registered
//  update_lbp_pred_o   out  IPF*PW     head lbp predictions, registered
//  update_is_unaligned_o out 1         resolved pc lies in block after head vpc
//  resolve_miss_o      out  1          pulse: resolve seen with queue empty
//  count_o             out  log2(DEPTH)+1 occupancy
//  stat_full_cycles_o  out  32         see CONFIGURATION
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge): head=tail=count=0; all outputs 0 except push_ready_o=1.
//  Storage: circular buffer, head/tail log2(DEPTH) bits, wrap DEPTH-1 -> 0; count separate (full=DEPTH, empty=0).
//  Push: push_valid_i & push_ready_o -> write entry at tail, tail++, count++. Push while full: dropped, no state change.
//  push_ready_o combinational from current count only; no same-cycle pop->push pass-through when full.
//  Resolve: resolve_valid_i & count>0 -> next cycle update_valid_o=1 with head fields; head++, count--.
//  Resolve latency exactly 1 cycle; update_valid_o is a single-cycle pulse per resolve.
//  Resolve with count==0: no pop, update_valid_o=0 next cycle, resolve_miss_o=1 next cycle (1-cycle pulse).
//  Push and resolve same cycle, count>0: both happen, count unchanged. With count==0: push only, resolve_miss_o=1 (no bypass).
//  update_is_unaligned_o = (resolve_pc_i[VLEN-1:OFF] != head_vpc[VLEN-1:OFF]), OFF=$clog2(IPF*2); registered with update.
//  update_* data outputs hold last value while update_valid_o=0.
//  Flush: flush_i highest priority; head=tail=count=0 next cycle; push and resolve same cycle ignored;
//   update_valid_o/resolve_miss_o forced 0 next cycle. Data outputs hold.
//  Reset mid-operation: same as power-on reset; in-flight entries lost.
// CONFIGURATION
//  FTQ_STATS_EN defined: stat_full_cycles_o counts cycles with push_valid_i=1 & count==DEPTH;
//   saturates at 32'hFFFF_FFFF; cleared by reset only, not by flush.
//  FTQ_STATS_EN undefined: stat_full_cycles_o tied to 0, no counter flops.
// TESTING
//  T1 push 3 blocks (gindex 0x11,0x22,0x33), resolve x3 back-to-back -> update_valid_o 1 cycle after each, gindex 0x11,0x22,0x33, count 3->0.
//  T2 fill DEPTH=8, push 9th -> push_ready_o=0, entry dropped; resolve 8 -> gindex order intact, 9th never appears.
//  T3 resolve on empty queue -> resolve_miss_o=1 next cycle, update_valid_o=0, count stays 0.
//  T4 count=5, flush_i with push_valid_i and resolve_valid_i high -> count=0 next cycle, no update_valid_o, push_ready_o=1.
//  T5 head vpc=0x1000, IPF=2, resolve_pc 0x1004 -> update_is_unaligned_o=1; resolve_pc 0x1002 -> 0.
//  T6 FTQ_STATS_EN: hold full with push_valid_i=1 for 10 cycles -> stat_full_cycles_o=10; flush, still 10; reset -> 0.

Source files
------------

// File: rtl/bp_meta_ftq.sv
// Purpose: fetch-target metadata queue; captures predictor gindex/lindex and per-slot gbp/lbp
//          predictions per fetch block, replays them in order to the predictor update ports.
// Latency: resolve -> update_* outputs exactly 1 cycle (registered); flush clears the queue next cycle.
// Backpressure: push_ready_o low while count==DEPTH; pushes while full are dropped, no pop->push bypass.
//
// Ports:
//   clk_i, rst_ni (synchronous, active low), flush_i
//   push_*     : fetch-block metadata capture (valid/ready)
//   resolve_*  : in-order branch resolution, retires the head entry
//   update_*   : registered head metadata for the predictor update, pulse-qualified by update_valid_o
//   resolve_miss_o : 1-cycle pulse when a resolve arrives with the queue empty
//   count_o    : occupancy
//   stat_full_cycles_o : cycles with push_valid_i while full (only when FTQ_STATS_EN is defined, else 0)
//
// Optional feature macro: FTQ_STATS_EN
module bp_meta_ftq #(
    parameter int unsigned VLEN  = 64,
    parameter int unsigned IPF   = 2,
    parameter int unsigned GW    = 10,
    parameter int unsigned LW    = 10,
    parameter int unsigned PW    = 2,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1,
    localparam int unsigned SW   = IPF * PW
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_valid_i,
    output logic            push_ready_o,
    input  logic [VLEN-1:0] push_vpc_i,
    input  logic [GW-1:0]   push_gindex_i,
    input  logic [LW-1:0]   push_lindex_i,
    input  logic [SW-1:0]   push_gbp_pred_i,
    input  logic [SW-1:0]   push_lbp_pred_i,
    input  logic            resolve_valid_i,
    input  logic [VLEN-1:0] resolve_pc_i,
    output logic            update_valid_o,
    output logic [GW-1:0]   update_gindex_o,
    output logic [LW-1:0]   update_lindex_o,
    output logic [SW-1:0]   update_gbp_pred_o,
    output logic [SW-1:0]   update_lbp_pred_o,
    output logic            update_is_unaligned_o,
    output logic            resolve_miss_o,
    output logic [CW-1:0]   count_o,
    output logic [31:0]     stat_full_cycles_o
);

    // Byte offset bits inside one fetch block (compressed instructions are 2 bytes).
    localparam int unsigned OFF = $clog2(IPF * 2);

    logic [VLEN-1:0] vpc_q    [DEPTH];
    logic [GW-1:0]   gindex_q [DEPTH];
    logic [LW-1:0]   lindex_q [DEPTH];
    logic [SW-1:0]   gbp_q    [DEPTH];
    logic [SW-1:0]   lbp_q    [DEPTH];

    logic [AW-1:0]   head_q;
    logic [AW-1:0]   tail_q;
    logic [CW-1:0]   count_q;

    logic            full;
    logic            empty;
    logic            do_push;
    logic            do_pop;
    logic            do_miss;
    logic [VLEN-1:0] pc_diff;
    logic            unaligned;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign push_ready_o = ~full;
    assign count_o      = count_q;

    // Flush outranks everything; a resolve on an empty queue never sees a same-cycle push.
    assign do_push = push_valid_i & ~full & ~flush_i;
    assign do_pop  = resolve_valid_i & ~empty & ~flush_i;
    assign do_miss = resolve_valid_i & empty & ~flush_i;

    // Resolved pc falls outside the head's fetch block when any bit above the block offset differs.
    assign pc_diff   = resolve_pc_i ^ vpc_q[head_q];
    assign unaligned = |(pc_diff >> OFF);

    // Payload storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (rst_ni && do_push) begin
            vpc_q[tail_q]    <= push_vpc_i;
            gindex_q[tail_q] <= push_gindex_i;
            lindex_q[tail_q] <= push_lindex_i;
            gbp_q[tail_q]    <= push_gbp_pred_i;
            lbp_q[tail_q]    <= push_lbp_pred_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q                <= '0;
            tail_q                <= '0;
            count_q               <= '0;
            update_valid_o        <= 1'b0;
            update_gindex_o       <= '0;
            update_lindex_o       <= '0;
            update_gbp_pred_o     <= '0;
            update_lbp_pred_o     <= '0;
            update_is_unaligned_o <= 1'b0;
            resolve_miss_o        <= 1'b0;
        end else if (flush_i) begin
            // Data outputs deliberately hold their last value across a flush.
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            update_valid_o <= 1'b0;
            resolve_miss_o <= 1'b0;
        end else begin
            update_valid_o <= do_pop;
            resolve_miss_o <= do_miss;
            if (do_push) begin
                tail_q <= tail_q + AW'(1);
            end
            if (do_pop) begin
                head_q                <= head_q + AW'(1);
                update_gindex_o       <= gindex_q[head_q];
                update_lindex_o       <= lindex_q[head_q];
                update_gbp_pred_o     <= gbp_q[head_q];
                update_lbp_pred_o     <= lbp_q[head_q];
                update_is_unaligned_o <= unaligned;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

`ifdef FTQ_STATS_EN
    // Counts push attempts turned away by a full queue; survives flush, cleared only by reset.
    logic [31:0] stat_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_q <= '0;
        end else if (push_valid_i && full && (stat_q != 32'hFFFF_FFFF)) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stat_full_cycles_o = stat_q;
`else
    assign stat_full_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_bp_meta_ftq.sv
// Purpose: self-checking bench for bp_meta_ftq; queue-based reference model, directed and random stimulus.
// Latency: outputs checked 1 time unit after each rising edge, inputs driven at the same point.
// Backpressure: model drops pushes while it holds DEPTH entries, mirroring the queue's contract.
module tb_bp_meta_ftq;

    localparam int VLEN  = 32;
    localparam int IPF   = 2;
    localparam int GW    = 8;
    localparam int LW    = 8;
    localparam int PW    = 2;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SW    = IPF * PW;
    localparam int OFF   = $clog2(IPF * 2);
`ifdef FTQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            push_valid_i;
    logic            push_ready_o;
    logic [VLEN-1:0] push_vpc_i;
    logic [GW-1:0]   push_gindex_i;
    logic [LW-1:0]   push_lindex_i;
    logic [SW-1:0]   push_gbp_pred_i;
    logic [SW-1:0]   push_lbp_pred_i;
    logic            resolve_valid_i;
    logic [VLEN-1:0] resolve_pc_i;
    logic            update_valid_o;
    logic [GW-1:0]   update_gindex_o;
    logic [LW-1:0]   update_lindex_o;
    logic [SW-1:0]   update_gbp_pred_o;
    logic [SW-1:0]   update_lbp_pred_o;
    logic            update_is_unaligned_o;
    logic            resolve_miss_o;
    logic [CW-1:0]   count_o;
    logic [31:0]     stat_full_cycles_o;

    always #5 clk = ~clk;

    bp_meta_ftq #(
        .VLEN(VLEN), .IPF(IPF), .GW(GW), .LW(LW), .PW(PW), .DEPTH(DEPTH)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .push_valid_i          (push_valid_i),
        .push_ready_o          (push_ready_o),
        .push_vpc_i            (push_vpc_i),
        .push_gindex_i         (push_gindex_i),
        .push_lindex_i         (push_lindex_i),
        .push_gbp_pred_i       (push_gbp_pred_i),
        .push_lbp_pred_i       (push_lbp_pred_i),
        .resolve_valid_i       (resolve_valid_i),
        .resolve_pc_i          (resolve_pc_i),
        .update_valid_o        (update_valid_o),
        .update_gindex_o       (update_gindex_o),
        .update_lindex_o       (update_lindex_o),
        .update_gbp_pred_o     (update_gbp_pred_o),
        .update_lbp_pred_o     (update_lbp_pred_o),
        .update_is_unaligned_o (update_is_unaligned_o),
        .resolve_miss_o        (resolve_miss_o),
        .count_o               (count_o),
        .stat_full_cycles_o    (stat_full_cycles_o)
    );

    typedef struct {
        logic [VLEN-1:0] vpc;
        logic [GW-1:0]   g;
        logic [LW-1:0]   l;
        logic [SW-1:0]   gb;
        logic [SW-1:0]   lb;
    } ent_t;

    // Reference model: an in-order list of captured blocks plus the last replayed fields.
    ent_t            mq[$];
    logic            exp_valid, exp_miss, exp_un;
    logic [GW-1:0]   exp_g;
    logic [LW-1:0]   exp_l;
    logic [SW-1:0]   exp_gb, exp_lb;
    logic [31:0]     exp_stat;

    int vectors = 0;
    int miscompares = 0;

    task automatic cycle(input logic r, input logic f, input logic pv, input logic [VLEN-1:0] pvpc,
                         input logic [GW-1:0] g, input logic rv, input logic [VLEN-1:0] rpc);
        int   n;
        ent_t e;
        ent_t ne;
        ne.vpc = pvpc;
        ne.g   = g;
        ne.l   = LW'($urandom);
        ne.gb  = SW'($urandom);
        ne.lb  = SW'($urandom);
        rst_ni = r; flush_i = f; push_valid_i = pv; push_vpc_i = pvpc; push_gindex_i = g;
        push_lindex_i = ne.l; push_gbp_pred_i = ne.gb; push_lbp_pred_i = ne.lb;
        resolve_valid_i = rv; resolve_pc_i = rpc;
        n = mq.size();
        if (!r) begin
            mq.delete();
            exp_valid = 0; exp_miss = 0; exp_un = 0; exp_g = '0; exp_l = '0;
            exp_gb = '0; exp_lb = '0; exp_stat = 0;
        end else begin
            if (pv && n == DEPTH && exp_stat != 32'hFFFF_FFFF) exp_stat = exp_stat + 1;
            exp_valid = 0;
            exp_miss  = 0;
            if (f) begin
                mq.delete();
            end else begin
                if (rv && n == 0) exp_miss = 1;
                if (rv && n > 0) begin
                    e = mq.pop_front();
                    exp_valid = 1; exp_g = e.g; exp_l = e.l; exp_gb = e.gb; exp_lb = e.lb;
                    exp_un = ((rpc >> OFF) != (e.vpc >> OFF));
                end
                if (pv && n < DEPTH) mq.push_back(ne);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [GW-1:0] g, input logic [VLEN-1:0] vpc);
        cycle(1, 0, 1, vpc, g, 0, '0);
    endtask

    task automatic resolve(input logic [VLEN-1:0] pc);
        cycle(1, 0, 0, VLEN'($urandom), GW'($urandom), 1, pc);
    endtask

    task automatic idle();
        cycle(1, 0, 0, VLEN'($urandom), GW'($urandom), 0, '0);
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, '0, '0, 0, '0);
        cycle(0, 0, 1, '0, '0, 1, '0);
        vectors++; if (count_o !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        vectors++; if (push_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", push_ready_o); end
        vectors++;
        if ({update_valid_o, resolve_miss_o, update_is_unaligned_o, update_gindex_o, update_lindex_o,
             update_gbp_pred_o, update_lbp_pred_o, stat_full_cycles_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b m=%b u=%b g=%h l=%h gb=%h lb=%h st=%0d expected all 0",
                     update_valid_o, resolve_miss_o, update_is_unaligned_o, update_gindex_o, update_lindex_o,
                     update_gbp_pred_o, update_lbp_pred_o, stat_full_cycles_o);
        end
    endtask

    task automatic test_in_order();
        logic [GW-1:0] gs [3];
        gs[0] = 8'h11; gs[1] = 8'h22; gs[2] = 8'h33;
        for (int i = 0; i < 3; i++) push(gs[i], 32'h2000 + 32'(i * 4));
        vectors++; if (count_o !== CW'(3)) begin miscompares++; $display("FAIL t1_count3: got %0d expected 3", count_o); end
        for (int i = 0; i < 3; i++) begin
            resolve(32'h2000 + 32'(i * 4));
            vectors++;
            if (update_valid_o !== 1'b1 || update_gindex_o !== gs[i] || update_lindex_o !== exp_l ||
                update_gbp_pred_o !== exp_gb || update_lbp_pred_o !== exp_lb) begin
                miscompares++;
                $display("FAIL t1_update%0d: got v=%b g=%h l=%h gb=%h lb=%h expected v=1 g=%h l=%h gb=%h lb=%h", i,
                         update_valid_o, update_gindex_o, update_lindex_o, update_gbp_pred_o, update_lbp_pred_o,
                         gs[i], exp_l, exp_gb, exp_lb);
            end
            vectors++; if (count_o !== CW'(2 - i)) begin miscompares++; $display("FAIL t1_count: got %0d expected %0d", count_o, 2 - i); end
        end
        idle();
        vectors++; if (update_valid_o !== 1'b0) begin miscompares++; $display("FAIL t1_pulse: got %b expected 0", update_valid_o); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) push(GW'(i + 1), '0);
        vectors++; if (push_ready_o !== 1'b0) begin miscompares++; $display("FAIL t2_ready_full: got %b expected 0", push_ready_o); end
        push(8'hEE, '0);
        vectors++; if (count_o !== CW'(DEPTH)) begin miscompares++; $display("FAIL t2_count: got %0d expected %0d", count_o, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            resolve('0);
            vectors++;
            if (update_valid_o !== 1'b1 || update_gindex_o !== GW'(i + 1)) begin
                miscompares++;
                $display("FAIL t2_order%0d: got v=%b g=%h expected v=1 g=%h", i, update_valid_o, update_gindex_o, i + 1);
            end
        end
        resolve('0);
        vectors++;
        if (update_valid_o !== 1'b0 || resolve_miss_o !== 1'b1 || update_gindex_o !== GW'(DEPTH)) begin
            miscompares++;
            $display("FAIL t2_dropped: got v=%b m=%b g=%h expected v=0 m=1 g=%h", update_valid_o, resolve_miss_o,
                     update_gindex_o, DEPTH);
        end
    endtask

    task automatic test_empty_resolve();
        logic [GW-1:0] held;
        held = exp_g;
        resolve(32'h40);
        vectors++;
        if (resolve_miss_o !== 1'b1 || update_valid_o !== 1'b0 || count_o !== '0 || update_gindex_o !== held) begin
            miscompares++;
            $display("FAIL t3_miss: got m=%b v=%b c=%0d g=%h expected m=1 v=0 c=0 g=%h", resolve_miss_o,
                     update_valid_o, count_o, update_gindex_o, held);
        end
        cycle(1, 0, 1, 32'h80, 8'h5A, 1, 32'h80);
        vectors++;
        if (resolve_miss_o !== 1'b1 || update_valid_o !== 1'b0 || count_o !== CW'(1)) begin
            miscompares++;
            $display("FAIL t3_nobypass: got m=%b v=%b c=%0d expected m=1 v=0 c=1", resolve_miss_o, update_valid_o, count_o);
        end
        cycle(1, 0, 1, 32'h90, 8'h5B, 1, 32'h80);
        vectors++;
        if (resolve_miss_o !== 1'b0 || update_valid_o !== 1'b1 || update_gindex_o !== 8'h5A || count_o !== CW'(1)) begin
            miscompares++;
            $display("FAIL t3_pushpop: got m=%b v=%b g=%h c=%0d expected m=0 v=1 g=5a c=1", resolve_miss_o,
                     update_valid_o, update_gindex_o, count_o);
        end
        resolve(32'h90);
    endtask

    task automatic test_flush();
        logic [GW-1:0] held;
        for (int i = 0; i < 5; i++) push(GW'(8'h60 + i), '0);
        held = update_gindex_o;
        vectors++; if (count_o !== CW'(5)) begin miscompares++; $display("FAIL t4_count5: got %0d expected 5", count_o); end
        cycle(1, 1, 1, '0, 8'h77, 1, '0);
        vectors++;
        if (count_o !== '0 || update_valid_o !== 1'b0 || resolve_miss_o !== 1'b0 || push_ready_o !== 1'b1 ||
            update_gindex_o !== held) begin
            miscompares++;
            $display("FAIL t4_flush: got c=%0d v=%b m=%b r=%b g=%h expected c=0 v=0 m=0 r=1 g=%h", count_o,
                     update_valid_o, resolve_miss_o, push_ready_o, update_gindex_o, held);
        end
    endtask

    task automatic test_unaligned();
        push(8'h01, 32'h1000);
        push(8'h02, 32'h1000);
        resolve(32'h1004);
        vectors++; if (update_is_unaligned_o !== 1'b1) begin miscompares++; $display("FAIL t5_unaligned: got %b expected 1", update_is_unaligned_o); end
        resolve(32'h1002);
        vectors++; if (update_is_unaligned_o !== 1'b0) begin miscompares++; $display("FAIL t5_aligned: got %b expected 0", update_is_unaligned_o); end
    endtask

    task automatic test_stats();
        logic [31:0] want;
        cycle(0, 0, 0, '0, '0, 0, '0);
        for (int i = 0; i < DEPTH; i++) push(GW'(i), '0);
        for (int i = 0; i < 10; i++) push(8'hFF, '0);
        want = STATS ? 32'd10 : 32'd0;
        vectors++; if (stat_full_cycles_o !== want) begin miscompares++; $display("FAIL t6_count: got %0d expected %0d", stat_full_cycles_o, want); end
        cycle(1, 1, 0, '0, '0, 0, '0);
        vectors++; if (stat_full_cycles_o !== want) begin miscompares++; $display("FAIL t6_flush: got %0d expected %0d", stat_full_cycles_o, want); end
        cycle(0, 0, 0, '0, '0, 0, '0);
        vectors++; if (stat_full_cycles_o !== 32'd0) begin miscompares++; $display("FAIL t6_reset: got %0d expected 0", stat_full_cycles_o); end
    endtask

    task automatic test_random();
        logic [31:0] st;
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 79) != 0), ($urandom_range(0, 23) == 0), ($urandom_range(0, 99) < 60),
                  VLEN'($urandom_range(0, 15) * 4), GW'($urandom), ($urandom_range(0, 99) < 45),
                  VLEN'($urandom_range(0, 15) * 4));
            st = STATS ? exp_stat : 32'd0;
            vectors++;
            if ({update_valid_o, resolve_miss_o, count_o, push_ready_o, update_gindex_o, update_lindex_o,
                 update_gbp_pred_o, update_lbp_pred_o, update_is_unaligned_o, stat_full_cycles_o} !==
                {exp_valid, exp_miss, CW'(mq.size()), (mq.size() < DEPTH), exp_g, exp_l, exp_gb, exp_lb,
                 exp_un, st}) begin
                miscompares++;
                $display("FAIL rand%0d: got v=%b m=%b c=%0d r=%b g=%h l=%h gb=%h lb=%h u=%b st=%0d expected v=%b m=%b c=%0d g=%h l=%h gb=%h lb=%h u=%b st=%0d",
                         i, update_valid_o, resolve_miss_o, count_o, push_ready_o, update_gindex_o, update_lindex_o,
                         update_gbp_pred_o, update_lbp_pred_o, update_is_unaligned_o, stat_full_cycles_o,
                         exp_valid, exp_miss, mq.size(), exp_g, exp_l, exp_gb, exp_lb, exp_un, st);
            end
        end
    endtask

    initial begin
        rst_ni = 0; flush_i = 0; push_valid_i = 0; push_vpc_i = '0; push_gindex_i = '0; push_lindex_i = '0;
        push_gbp_pred_i = '0; push_lbp_pred_i = '0; resolve_valid_i = 0; resolve_pc_i = '0;
        #2;
        test_reset();
        test_in_order();
        test_full();
        test_empty_resolve();
        test_flush();
        test_unaligned();
        test_stats();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
